// File: rtl/cpu_regfile.sv
// SM83 architectural register file: 8-bit ALU operand ports, CHNZ flags, 16-bit pairs, and the IDU.
// Optional macro REGFILE_POST_BOOT_EN: reset loads the DMG post-boot register state instead of all zeros.
module cpu_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rd_a_sel,
   output logic [7:0]  rd_a_data,
   input  logic [3:0]  rd_b_sel,
   output logic [7:0]  rd_b_data,
   input  logic        wr8_en,
   input  logic [3:0]  wr8_sel,
   input  logic [7:0]  wr8_data,
   input  logic        flag_wr_en,
   input  logic [3:0]  flag_in,
   output logic [3:0]  flags,
   input  logic        wr16_en,
   input  logic [2:0]  wr16_sel,
   input  logic [15:0] wr16_data,
   input  logic [2:0]  rd16_sel,
   output logic [15:0] rd16_data,
   input  logic        idu_en,
   input  logic        idu_dec,
   input  logic [2:0]  idu_sel,
   output logic [15:0] pc
);

   localparam int NP = 6;
   // Pair order BC, DE, HL, SP, PC, WZ; 8-bit codes of each pair's high and low byte.
   localparam logic [3:0] HI_CODE [NP] = '{4'd0, 4'd2, 4'd4, 4'd9,  4'd11, 4'd13};
   localparam logic [3:0] LO_CODE [NP] = '{4'd1, 4'd3, 4'd5, 4'd10, 4'd12, 4'd14};
   localparam logic [3:0] CODE_A = 4'd7;
   localparam logic [3:0] CODE_F = 4'd8;

`ifdef REGFILE_POST_BOOT_EN
   localparam logic [7:0]  RST_A = 8'h01;
   localparam logic [3:0]  RST_F = 4'hB;
   localparam logic [15:0] RST_PAIR [NP] =
      '{16'h0013, 16'h00D8, 16'h014D, 16'hFFFE, 16'h0100, 16'h0000};
`else
   localparam logic [7:0]  RST_A = 8'h00;
   localparam logic [3:0]  RST_F = 4'h0;
   localparam logic [15:0] RST_PAIR [NP] =
      '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif

   logic [15:0] pair_q [NP];
   logic [15:0] pair_d [NP];
   logic [7:0]  a_q, a_d;
   logic [3:0]  f_q, f_d;   // F[7:4] only; the low nibble is never stored
   logic [7:0]  byte_view [16];

   // Later assignments win, giving per-byte priority wr16 > wr8 > flags > idu.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         pair_d[p] = pair_q[p];
         if (idu_en && idu_sel == 3'(p))
            pair_d[p] = idu_dec ? pair_q[p] - 16'd1 : pair_q[p] + 16'd1;
         if (wr8_en && wr8_sel == HI_CODE[p])
            pair_d[p][15:8] = wr8_data;
         if (wr8_en && wr8_sel == LO_CODE[p])
            pair_d[p][7:0] = wr8_data;
         if (wr16_en && wr16_sel == 3'(p))
            pair_d[p] = wr16_data;
      end
      a_d = (wr8_en && wr8_sel == CODE_A) ? wr8_data : a_q;
      f_d = f_q;
      if (flag_wr_en)
         f_d = flag_in;
      if (wr8_en && wr8_sel == CODE_F)
         f_d = wr8_data[7:4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= RST_A;
         f_q <= RST_F;
         for (int p = 0; p < NP; p++)
            pair_q[p] <= RST_PAIR[p];
      end else begin
         a_q <= a_d;
         f_q <= f_d;
         for (int p = 0; p < NP; p++)
            pair_q[p] <= pair_d[p];
      end
   end

   // Codes 6 and 15 are left at zero.
   always_comb begin
      for (int i = 0; i < 16; i++)
         byte_view[i] = 8'h00;
      for (int p = 0; p < NP; p++) begin
         byte_view[HI_CODE[p]] = pair_q[p][15:8];
         byte_view[LO_CODE[p]] = pair_q[p][7:0];
      end
      byte_view[CODE_A] = a_q;
      byte_view[CODE_F] = {f_q, 4'h0};
   end

   always_comb begin
      case (rd16_sel)
         3'd0:    rd16_data = pair_q[0];
         3'd1:    rd16_data = pair_q[1];
         3'd2:    rd16_data = pair_q[2];
         3'd3:    rd16_data = pair_q[3];
         3'd4:    rd16_data = pair_q[4];
         3'd5:    rd16_data = pair_q[5];
         default: rd16_data = 16'h0000;
      endcase
   end

   assign rd_a_data = byte_view[rd_a_sel];
   assign rd_b_data = byte_view[rd_b_sel];
   assign flags     = f_q;
   assign pc        = pair_q[4];

endmodule

// File: tb/tb_cpu_regfile.sv
// Randomized and directed bench for cpu_regfile against a byte-array model indexed by 8-bit register code.
module tb_cpu_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rd_a_sel, rd_b_sel, wr8_sel, flag_in;
   logic [7:0]  rd_a_data, rd_b_data, wr8_data;
   logic        wr8_en, flag_wr_en, wr16_en, idu_en, idu_dec;
   logic [3:0]  flags;
   logic [2:0]  wr16_sel, rd16_sel, idu_sel;
   logic [15:0] wr16_data, rd16_data, pc;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: one byte per 8-bit register code; codes 6 and 15 never written.
   logic [7:0] m [16];
   int hi_tab [6] = '{0, 2, 4, 9, 11, 13};
   int lo_tab [6] = '{1, 3, 5, 10, 12, 14};

   cpu_regfile dut (
      .clk(clk), .reset(reset),
      .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
      .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
      .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data),
      .flag_wr_en(flag_wr_en), .flag_in(flag_in), .flags(flags),
      .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data),
      .rd16_sel(rd16_sel), .rd16_data(rd16_data),
      .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_rd16(input logic [2:0] sel);
      if (sel > 3'd5) return 16'h0000;
      return {m[hi_tab[sel]], m[lo_tab[sel]]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
`ifdef REGFILE_POST_BOOT_EN
      m[7] = 8'h01; m[8] = 8'hB0; m[1] = 8'h13; m[3] = 8'hD8;
      m[4] = 8'h01; m[5] = 8'h4D; m[9] = 8'hFF; m[10] = 8'hFE; m[11] = 8'h01;
`endif
   endtask

   // Apply sources lowest priority first so higher ones overwrite per byte.
   task automatic model_step();
      logic [7:0]  n [16];
      logic [15:0] v;
      for (int i = 0; i < 16; i++) n[i] = m[i];
      if (idu_en && idu_sel <= 3'd5) begin
         v = model_rd16(idu_sel);
         v = idu_dec ? v - 16'd1 : v + 16'd1;
         n[hi_tab[idu_sel]] = v[15:8];
         n[lo_tab[idu_sel]] = v[7:0];
      end
      if (flag_wr_en) n[8] = {flag_in, 4'h0};
      if (wr8_en && wr8_sel != 4'd6 && wr8_sel != 4'd15)
         n[wr8_sel] = (wr8_sel == 4'd8) ? {wr8_data[7:4], 4'h0} : wr8_data;
      if (wr16_en && wr16_sel <= 3'd5) begin
         n[hi_tab[wr16_sel]] = wr16_data[15:8];
         n[lo_tab[wr16_sel]] = wr16_data[7:0];
      end
      for (int i = 0; i < 16; i++) m[i] = n[i];
   endtask

   task automatic check_all(input string tag);
      check({tag, "_rd_a"}, 32'(rd_a_data), 32'(m[rd_a_sel]));
      check({tag, "_rd_b"}, 32'(rd_b_data), 32'(m[rd_b_sel]));
      check({tag, "_rd16"}, 32'(rd16_data), 32'(model_rd16(rd16_sel)));
      check({tag, "_pc"},   32'(pc),        32'(model_rd16(3'd4)));
      check({tag, "_flags"}, 32'(flags),    32'(m[8][7:4]));
   endtask

   task automatic set_idle();
      wr8_en = 0; wr8_sel = 0; wr8_data = 0;
      flag_wr_en = 0; flag_in = 0;
      wr16_en = 0; wr16_sel = 0; wr16_data = 0;
      idu_en = 0; idu_dec = 0; idu_sel = 0;
   endtask

   // Called just after a falling edge with inputs set: check pre-edge view, clock, update model.
   task automatic do_cycle(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wr8(input logic [3:0] sel, input logic [7:0] d);
      wr8_en = 1; wr8_sel = sel; wr8_data = d;
   endtask

   task automatic wr16(input logic [2:0] sel, input logic [15:0] d);
      wr16_en = 1; wr16_sel = sel; wr16_data = d;
   endtask

   initial begin
      reset = 1;
      rd_a_sel = 0; rd_b_sel = 0; rd16_sel = 0;
      set_idle();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state across every read code, while reset still high.
      for (int i = 0; i < 16; i++) begin
         rd_a_sel = 4'(i); rd_b_sel = 4'(15 - i);
         #1 check("rst_rd_a", 32'(rd_a_data), 32'(m[i]));
         check("rst_rd_b", 32'(rd_b_data), 32'(m[15 - i]));
      end
      for (int i = 0; i < 8; i++) begin
         rd16_sel = 3'(i);
         #1 check("rst_rd16", 32'(rd16_data), 32'(model_rd16(3'(i))));
      end
      rd_a_sel = 4'd7; rd16_sel = 3'd3;
`ifdef REGFILE_POST_BOOT_EN
      #1 check("rst_a_const", 32'(rd_a_data), 32'h01);
      check("rst_sp_const", 32'(rd16_data), 32'hFFFE);
      check("rst_pc_const", 32'(pc), 32'h0100);
      check("rst_flags_const", 32'(flags), 32'hB);
`else
      #1 check("rst_a_const", 32'(rd_a_data), 32'h00);
      check("rst_sp_const", 32'(rd16_data), 32'h0000);
      check("rst_pc_const", 32'(pc), 32'h0000);
      check("rst_flags_const", 32'(flags), 32'h0);
`endif
      reset = 0;
      @(negedge clk);

      // Write to A is not visible in the same cycle, visible in the next.
      rd_a_sel = 4'd7;
      wr8(4'd7, 8'h3C);
      do_cycle("wr_a");
      set_idle();
      #1 check("a_after_wr", 32'(rd_a_data), 32'h3C);
      wr8(4'd8, 8'hFF);
      do_cycle("wr_f");
      set_idle(); rd_a_sel = 4'd8;
      #1 check("f_after_wr", 32'(rd_a_data), 32'hF0);
      check("flags_after_wr", 32'(flags), 32'hF);

      // IDU wrap on SP and PC.
      wr16(3'd3, 16'h0000); do_cycle("sp_zero"); set_idle();
      idu_en = 1; idu_dec = 1; idu_sel = 3'd3; do_cycle("sp_dec"); set_idle();
      rd16_sel = 3'd3;
      #1 check("sp_wrap", 32'(rd16_data), 32'hFFFF);
      wr16(3'd4, 16'hFFFF); do_cycle("pc_ffff"); set_idle();
      idu_en = 1; idu_dec = 0; idu_sel = 3'd4; do_cycle("pc_inc"); set_idle();
      #1 check("pc_wrap", 32'(pc), 32'h0000);

      // Per-byte collision priority on HL.
      wr16(3'd2, 16'h12FF); do_cycle("hl_init"); set_idle();
      idu_en = 1; idu_dec = 0; idu_sel = 3'd2; wr8(4'd5, 8'h55);
      do_cycle("hl_idu_wr8"); set_idle();
      rd16_sel = 3'd2;
      #1 check("hl_mixed", 32'(rd16_data), 32'h1355);
      wr16(3'd2, 16'hABCD); wr8(4'd4, 8'h00);
      do_cycle("hl_wr16_wr8"); set_idle();
      #1 check("hl_wr16_wins", 32'(rd16_data), 32'hABCD);

      // Flag write versus wr8 to F, then async reset with no clock edge.
      rd_a_sel = 4'd8;
      flag_wr_en = 1; flag_in = 4'b0101; wr8(4'd8, 8'h00);
      do_cycle("f_collide"); set_idle();
      #1 check("f_wr8_wins", 32'(rd_a_data), 32'h00);
      flag_wr_en = 1; flag_in = 4'b0101;
      do_cycle("f_flags"); set_idle();
      #1 check("f_from_flags", 32'(rd_a_data), 32'h50);
      check("flags_0101", 32'(flags), 32'h5);
      #1 reset = 1;
      #1 model_reset();
`ifdef REGFILE_POST_BOOT_EN
      check("f_async_rst", 32'(rd_a_data), 32'hB0);
`else
      check("f_async_rst", 32'(rd_a_data), 32'h00);
`endif
      check_all("async_rst");
      // Writes presented while reset is high are dropped.
      rd_a_sel = 4'd7; wr8(4'd7, 8'h77);
      @(posedge clk); @(negedge clk);
      reset = 0;
      #1 check_all("held_rst");
      do_cycle("first_wr");
      set_idle();
      #1 check("first_wr_a", 32'(rd_a_data), 32'h77);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         rd_a_sel   = 4'($urandom_range(0, 15));
         rd_b_sel   = 4'($urandom_range(0, 15));
         rd16_sel   = 3'($urandom_range(0, 7));
         wr8_en     = 1'($urandom_range(0, 1));
         wr8_sel    = 4'($urandom_range(0, 15));
         wr8_data   = 8'($urandom);
         flag_wr_en = 1'($urandom_range(0, 1));
         flag_in    = 4'($urandom);
         wr16_en    = ($urandom_range(0, 3) == 0);
         wr16_sel   = 3'($urandom_range(0, 7));
         wr16_data  = 16'($urandom);
         idu_en     = 1'($urandom_range(0, 1));
         idu_dec    = 1'($urandom_range(0, 1));
         idu_sel    = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) wr16_data = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) wr16_data = 16'h0000;
         do_cycle("rand");
      end
      set_idle();
      #1 check_all("final");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
